// File: rtl/sram_req_bridge.sv
// sram_req_bridge: credit-limited bridge from a core request/response channel to a synchronous SRAM port.
// Define SRAM_BRIDGE_STAT_EN to add the stat_reqs / stat_req_stall / stat_resp_stall counters.
module sram_req_bridge #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int RESP_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req_valid,
   input  logic                  req_wr,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_strb,
   output logic                  req_ack,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_data,
   input  logic                  resp_ack,
   output logic                  sram_en,
   output logic [DATA_W/8-1:0]   sram_wen,
   output logic [ADDR_W-1:0]     sram_addr,
   output logic [DATA_W-1:0]     sram_wdata,
   input  logic [DATA_W-1:0]     sram_rdata,
   output logic                  busy
`ifdef SRAM_BRIDGE_STAT_EN
   ,
   output logic [31:0]           stat_reqs,
   output logic [31:0]           stat_req_stall,
   output logic [31:0]           stat_resp_stall
`endif
);

   localparam int STRB_W = DATA_W / 8;
   localparam int PTR_W  = $clog2(RESP_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int OUT_W  = $clog2(RESP_DEPTH + RD_LAT + 1);
   localparam logic [OUT_W-1:0] DEPTH_O = OUT_W'(RESP_DEPTH);

   logic [RD_LAT-1:0] pend_q, pend_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [RESP_DEPTH];
   logic [DATA_W-1:0] mem_d [RESP_DEPTH];

   logic [OUT_W-1:0]  in_flight;
   logic [OUT_W-1:0]  outstanding;
   logic              rd_acc;
   logic              push;
   logic              pop;

   // Credit covers reads still in the SRAM pipe as well as buffered responses,
   // so every accepted read is guaranteed a FIFO slot when its data returns.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         in_flight = in_flight + OUT_W'(pend_q[i]);
      end
   end

   assign outstanding = OUT_W'(cnt_q) + in_flight;
   assign req_ack     = resetn & (req_wr | (outstanding < DEPTH_O));

   assign sram_en    = req_valid & req_ack;
   assign sram_wen   = {STRB_W{req_wr & sram_en}} & req_strb;
   assign sram_addr  = req_addr;
   assign sram_wdata = req_wdata;

   assign rd_acc     = sram_en & ~req_wr;
   assign push       = pend_q[RD_LAT-1];
   assign resp_valid = (cnt_q != '0);
   assign pop        = resp_valid & resp_ack;
   assign resp_data  = resp_valid ? mem_q[rd_ptr_q] : '0;
   assign busy       = (|pend_q) | resp_valid;

   always_comb begin
      pend_d    = '0;
      pend_d[0] = rd_acc;
      for (int i = 1; i < RD_LAT; i++) begin
         pend_d[i] = pend_q[i-1];
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push) begin
         mem_d[wr_ptr_q] = sram_rdata;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         pend_q   <= pend_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: resp_data is masked whenever the count is zero.
   always_ff @(posedge clk) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

`ifdef SRAM_BRIDGE_STAT_EN
   logic [31:0] stat_reqs_q, stat_reqs_d;
   logic [31:0] stat_req_stall_q, stat_req_stall_d;
   logic [31:0] stat_resp_stall_q, stat_resp_stall_d;

   always_comb begin
      stat_reqs_d       = stat_reqs_q;
      stat_req_stall_d  = stat_req_stall_q;
      stat_resp_stall_d = stat_resp_stall_q;
      if (sram_en) begin
         stat_reqs_d = stat_reqs_q + 32'd1;
      end
      if (req_valid & ~req_ack) begin
         stat_req_stall_d = stat_req_stall_q + 32'd1;
      end
      if (resp_valid & ~resp_ack) begin
         stat_resp_stall_d = stat_resp_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_reqs_q       <= '0;
         stat_req_stall_q  <= '0;
         stat_resp_stall_q <= '0;
      end else begin
         stat_reqs_q       <= stat_reqs_d;
         stat_req_stall_q  <= stat_req_stall_d;
         stat_resp_stall_q <= stat_resp_stall_d;
      end
   end

   assign stat_reqs       = stat_reqs_q;
   assign stat_req_stall  = stat_req_stall_q;
   assign stat_resp_stall = stat_resp_stall_q;
`endif

endmodule

// File: tb/tb_sram_req_bridge.sv
// Directed bench for sram_req_bridge: three instances (RD_LAT/RESP_DEPTH = 1/4, 3/4, 1/2),
// each with its own SRAM model preloaded with addr ^ 0xA5A5A5A5 (0x40 holds 0x11223344).
module tb_sram_req_bridge;

   localparam logic [31:0] PAT = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid  [3];
   logic        req_wr     [3];
   logic [31:0] req_addr   [3];
   logic [31:0] req_wdata  [3];
   logic [3:0]  req_strb   [3];
   logic        req_ack    [3];
   logic        resp_valid [3];
   logic [31:0] resp_data  [3];
   logic        resp_ack   [3];
   logic        sram_en    [3];
   logic [3:0]  sram_wen   [3];
   logic [31:0] sram_addr  [3];
   logic [31:0] sram_wdata [3];
   logic [31:0] sram_rdata [3];
   logic        busy       [3];
`ifdef SRAM_BRIDGE_STAT_EN
   logic [31:0] stat_reqs       [3];
   logic [31:0] stat_req_stall  [3];
   logic [31:0] stat_resp_stall [3];
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int G_LAT = (gi == 1) ? 3 : 1;
      localparam int G_DEP = (gi == 2) ? 2 : 4;

      logic [31:0] mem  [256];
      logic [31:0] pipe [4];
      logic [7:0]  idx;

      assign idx = sram_addr[gi][9:2];

      initial begin
         for (int i = 0; i < 256; i++) begin
            mem[i] <= 32'(i * 4) ^ PAT;
         end
         mem[16] <= 32'h11223344;
      end

      always @(posedge clk) begin
         if (sram_en[gi]) begin
            for (int b = 0; b < 4; b++) begin
               if (sram_wen[gi][b]) mem[idx][8*b +: 8] <= sram_wdata[gi][8*b +: 8];
            end
         end
         pipe[0] <= (sram_en[gi] && sram_wen[gi] == 4'h0) ? mem[idx] : 32'h0;
         for (int i = 1; i < 4; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end

      assign sram_rdata[gi] = pipe[G_LAT-1];

      always @(negedge clk) begin
         if (resetn) begin
            chk("no_push_into_full",
                32'(u_dut.pend_q[G_LAT-1] && (32'(u_dut.cnt_q) == G_DEP)), 32'd0);
         end
      end

      sram_req_bridge #(
         .ADDR_W    (32),
         .DATA_W    (32),
         .RD_LAT    (G_LAT),
         .RESP_DEPTH(G_DEP)
      ) u_dut (
         .clk       (clk),
         .resetn    (resetn),
         .req_valid (req_valid[gi]),
         .req_wr    (req_wr[gi]),
         .req_addr  (req_addr[gi]),
         .req_wdata (req_wdata[gi]),
         .req_strb  (req_strb[gi]),
         .req_ack   (req_ack[gi]),
         .resp_valid(resp_valid[gi]),
         .resp_data (resp_data[gi]),
         .resp_ack  (resp_ack[gi]),
         .sram_en   (sram_en[gi]),
         .sram_wen  (sram_wen[gi]),
         .sram_addr (sram_addr[gi]),
         .sram_wdata(sram_wdata[gi]),
         .sram_rdata(sram_rdata[gi]),
         .busy      (busy[gi])
`ifdef SRAM_BRIDGE_STAT_EN
         ,
         .stat_reqs      (stat_reqs[gi]),
         .stat_req_stall (stat_req_stall[gi]),
         .stat_resp_stall(stat_resp_stall[gi])
`endif
      );
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      int idx;
      int nresp;

      resetn = 1'b0;
      for (int g = 0; g < 3; g++) begin
         req_valid[g] = 1'b0;
         req_wr[g]    = 1'b0;
         req_addr[g]  = 32'h0;
         req_wdata[g] = 32'h0;
         req_strb[g]  = 4'h0;
         resp_ack[g]  = 1'b0;
      end
      req_valid[0] = 1'b1;
      req_wr[0]    = 1'b1;
      req_strb[0]  = 4'hF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ack", 32'(req_ack[0]), 32'd0);
      chk("rst_sram_en", 32'(sram_en[0]), 32'd0);
      chk("rst_sram_wen", 32'(sram_wen[0]), 32'd0);
      for (int g = 0; g < 3; g++) begin
         chk("rst_resp_valid", 32'(resp_valid[g]), 32'd0);
         chk("rst_busy", 32'(busy[g]), 32'd0);
         chk("rst_resp_data", resp_data[g], 32'd0);
      end
`ifdef SRAM_BRIDGE_STAT_EN
      chk("rst_stat_reqs", stat_reqs[1], 32'd0);
`endif
      req_valid[0] = 1'b0;
      req_wr[0]    = 1'b0;
      req_strb[0]  = 4'h0;
      @(posedge clk); #1;
      resetn = 1'b1;

      // back-to-back reads, RD_LAT=1
      resp_ack[0] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         req_valid[0] = (c < 8);
         req_wr[0]    = 1'b0;
         req_addr[0]  = 32'h100 + 32'(4 * c);
         @(negedge clk);
         if (c < 8) begin
            chk("s1_req_ack", 32'(req_ack[0]), 32'd1);
            chk("s1_sram_addr", sram_addr[0], 32'h100 + 32'(4 * c));
         end
         chk("s1_resp_valid", 32'(resp_valid[0]), 32'(c >= 2 && c < 10));
         if (c >= 2 && c < 10) begin
            chk("s1_resp_data", resp_data[0], (32'h100 + 32'(4 * (c - 2))) ^ PAT);
         end
      end
      chk("s1_busy_idle", 32'(busy[0]), 32'd0);

      // partial-strobe write then read-back
      @(posedge clk); #1;
      req_valid[0] = 1'b1;
      req_wr[0]    = 1'b1;
      req_addr[0]  = 32'h40;
      req_wdata[0] = 32'hDEADBEEF;
      req_strb[0]  = 4'b0101;
      @(negedge clk);
      chk("s3_wr_ack", 32'(req_ack[0]), 32'd1);
      chk("s3_wr_wen", 32'(sram_wen[0]), 32'h5);
      chk("s3_wr_wdata", sram_wdata[0], 32'hDEADBEEF);
      @(posedge clk); #1;
      req_wr[0]   = 1'b0;
      req_strb[0] = 4'hF;
      @(negedge clk);
      chk("s3_rd_wen", 32'(sram_wen[0]), 32'h0);
      chk("s3_rd_en", 32'(sram_en[0]), 32'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      req_strb[0]  = 4'h0;
      @(negedge clk);
      chk("s3_resp_early", 32'(resp_valid[0]), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("s3_resp_valid", 32'(resp_valid[0]), 32'd1);
      chk("s3_resp_data", resp_data[0], 32'h11AD33EF);

      // credit exhaustion on reads; writes still accepted
      @(posedge clk); #1;
      resp_ack[0] = 1'b0;
      for (int c = 0; c < 11; c++) begin
         @(posedge clk); #1;
         req_valid[0] = (c < 5);
         req_wr[0]    = (c == 4);
         req_addr[0]  = (c == 4) ? 32'h80 : 32'h300 + 32'(4 * c);
         req_wdata[0] = 32'h0;
         req_strb[0]  = (c == 4) ? 4'hF : 4'h0;
         resp_ack[0]  = (c >= 6);
         @(negedge clk);
         if (c < 4) chk("s3c_rd_ack", 32'(req_ack[0]), 32'd1);
         if (c == 4) begin
            chk("s3c_wr_ack_no_credit", 32'(req_ack[0]), 32'd1);
            chk("s3c_wr_wen", 32'(sram_wen[0]), 32'hF);
         end
         if (c == 5) chk("s3c_rd_ack_full", 32'(req_ack[0]), 32'd0);
         chk("s3c_resp_valid", 32'(resp_valid[0]), 32'(c >= 2 && c < 10));
         if (c >= 6 && c < 10) begin
            chk("s3c_resp_data", resp_data[0], (32'h300 + 32'(4 * (c - 6))) ^ PAT);
         end
      end

      // RD_LAT=3 with core back-pressure
      resp_ack[1] = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk); #1;
         req_valid[1] = (c <= 10);
         req_wr[1]    = 1'b0;
         req_addr[1]  = 32'h120 + 32'(4 * ((c < 4) ? c : 4));
         resp_ack[1]  = (c >= 10);
         @(negedge clk);
         chk("s2_req_ack", 32'(req_ack[1]), 32'(c < 4 || c >= 11));
         chk("s2_resp_valid", 32'(resp_valid[1]), 32'(c >= 4 && c <= 13));
         if (c >= 4 && c <= 13) begin
            chk("s2_resp_data", resp_data[1],
                (32'h120 + 32'(4 * ((c <= 10) ? 0 : c - 10))) ^ PAT);
         end
      end
      chk("s2_busy_idle", 32'(busy[1]), 32'd0);
`ifdef SRAM_BRIDGE_STAT_EN
      chk("s2_stat_reqs", stat_reqs[1], 32'd4);
      chk("s2_stat_req_stall", stat_req_stall[1], 32'd7);
      chk("s2_stat_resp_stall", stat_resp_stall[1], 32'd6);
`endif

      // RESP_DEPTH=2 wrap with toggling resp_ack
      idx   = 0;
      nresp = 0;
      for (int c = 0; c < 200 && nresp < 10; c++) begin
         @(posedge clk); #1;
         req_valid[2] = (idx < 10);
         req_wr[2]    = 1'b0;
         req_addr[2]  = 32'h200 + 32'(4 * idx);
         resp_ack[2]  = (c % 2 == 0);
         @(negedge clk);
         if (resp_valid[2] && resp_ack[2]) begin
            chk("s4_resp_data", resp_data[2], (32'h200 + 32'(4 * nresp)) ^ PAT);
            nresp++;
         end
         if (req_valid[2] && req_ack[2]) idx++;
         chk("s4_cnt_le2", 32'(32'(g_dut[2].u_dut.cnt_q) <= 2), 32'd1);
      end
      chk("s4_resp_count", 32'(nresp), 32'd10);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      resp_ack[2]  = 1'b0;
      @(negedge clk);
      chk("s4_busy_idle", 32'(busy[2]), 32'd0);

      // reset pulse with 2 reads in flight and 1 buffered
      resp_ack[1] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         req_valid[1] = (c < 3);
         req_addr[1]  = 32'h140 + 32'(4 * c);
         @(negedge clk);
      end
      chk("s5_pre_resp_valid", 32'(resp_valid[1]), 32'd1);
      chk("s5_pre_busy", 32'(busy[1]), 32'd1);
      #1;
      resetn = 1'b0;
      #1;
      chk("s5_rst_resp_valid", 32'(resp_valid[1]), 32'd0);
      chk("s5_rst_busy", 32'(busy[1]), 32'd0);
      chk("s5_rst_resp_data", resp_data[1], 32'd0);
      @(posedge clk); #1;
      resetn      = 1'b1;
      resp_ack[1] = 1'b1;
`ifdef SRAM_BRIDGE_STAT_EN
      chk("s5_stat_cleared", stat_reqs[1], 32'd0);
`endif
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("s5_no_stale_valid", 32'(resp_valid[1]), 32'd0);
         chk("s5_no_stale_busy", 32'(busy[1]), 32'd0);
         @(posedge clk); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
